pwm_cmd_sequencer: RTL and testbench

Packet parser and write sequencer between the UART receiver and the PWM duty register bank. It consumes the received byte stream, validates 4-byte command packets and issues one duty-register write per good packet over a valid/ready handshake. It also maintains the good-packet and error counters shown on the status display.

---
 rtl/pwm_cmd_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pwm_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cmd_sequencer.sv
// Parses A5/CH/DUTY/CSUM packets from the UART byte stream and writes each good packet into the duty bank.
// The write goes out the cycle after the CSUM byte and is held until ready; bytes that arrive meanwhile are dropped and counted as errors.
module pwm_cmd_sequencer #(
    parameter int NUM_CH  = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       duty_wr_en,
    output logic [3:0] duty_wr_ch,
    output logic [7:0] duty_wr_val,
    input  logic       duty_wr_ready,
    output logic [3:0] pkt_count,
    output logic [3:0] err_count,
    output logic       busy,
    output logic       csum_err,
    output logic       ch_err,
    output logic       timeout_err,
    output logic       drop_err
);

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         GW      = $clog2(TIMEOUT);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_SYNC = 3'd1,
        GOT_CH   = 3'd2,
        GOT_DUTY = 3'd3,
        WRITE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    ch_q, ch_d;
    logic [7:0]    duty_q, duty_d;
    logic          ch_bad_q, ch_bad_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    pkt_q, pkt_d;
    logic [3:0]    err_q, err_d;
    logic          busy_q;
    logic          csum_err_q, csum_err_d;
    logic          ch_err_q, ch_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic          drop_err_q, drop_err_d;
    logic          any_err;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        duty_d     = duty_q;
        ch_bad_d   = ch_bad_q;
        gap_d      = gap_q;
        pkt_d      = pkt_q;
        csum_err_d = 1'b0;
        ch_err_d   = 1'b0;
        tmo_err_d  = 1'b0;
        drop_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (rx_valid && rx_data == SYNC) begin
                    state_d = GOT_SYNC;
                end
            end
            GOT_SYNC, GOT_CH, GOT_DUTY: begin
                // A byte on the expiry cycle takes precedence over the timeout.
                if (rx_valid) begin
                    gap_d = '0;
                    case (state_q)
                        GOT_SYNC: begin
                            ch_d     = rx_data;
                            ch_bad_d = ({24'd0, rx_data} >= 32'(NUM_CH));
                            state_d  = GOT_CH;
                        end
                        GOT_CH: begin
                            duty_d  = rx_data;
                            state_d = GOT_DUTY;
                        end
                        default: begin
                            if (rx_data != (SYNC ^ ch_q ^ duty_q)) begin
                                csum_err_d = 1'b1;
                                state_d    = IDLE;
                            end else if (ch_bad_q) begin
                                ch_err_d = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                state_d = WRITE;
                            end
                        end
                    endcase
                end else if (gap_q == GAP_MAX) begin
                    tmo_err_d = 1'b1;
                    gap_d     = '0;
                    state_d   = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            WRITE: begin
                drop_err_d = rx_valid;
                if (duty_wr_ready) begin
                    pkt_d   = pkt_q + 4'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        any_err = csum_err_d | ch_err_d | tmo_err_d | drop_err_d;
        err_d   = (any_err && err_q != 4'hF) ? err_q + 4'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            duty_q     <= '0;
            ch_bad_q   <= 1'b0;
            gap_q      <= '0;
            pkt_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            csum_err_q <= 1'b0;
            ch_err_q   <= 1'b0;
            tmo_err_q  <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            duty_q     <= duty_d;
            ch_bad_q   <= ch_bad_d;
            gap_q      <= gap_d;
            pkt_q      <= pkt_d;
            err_q      <= err_d;
            busy_q     <= (state_d != IDLE);
            csum_err_q <= csum_err_d;
            ch_err_q   <= ch_err_d;
            tmo_err_q  <= tmo_err_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign duty_wr_en  = (state_q == WRITE);
    assign duty_wr_ch  = ch_q[3:0];
    assign duty_wr_val = duty_q;
    assign pkt_count   = pkt_q;
    assign err_count   = err_q;
    assign busy        = busy_q;
    assign csum_err    = csum_err_q;
    assign ch_err      = ch_err_q;
    assign timeout_err = tmo_err_q;
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Directed bench for pwm_cmd_sequencer: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_pwm_cmd_sequencer;

    localparam int NUM_CH  = 9;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       duty_wr_en;
    logic [3:0] duty_wr_ch;
    logic [7:0] duty_wr_val;
    logic       duty_wr_ready;
    logic [3:0] pkt_count;
    logic [3:0] err_count;
    logic       busy;
    logic       csum_err;
    logic       ch_err;
    logic       timeout_err;
    logic       drop_err;

    int checks = 0;
    int fails  = 0;

    pwm_cmd_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .duty_wr_en   (duty_wr_en),
        .duty_wr_ch   (duty_wr_ch),
        .duty_wr_val  (duty_wr_val),
        .duty_wr_ready(duty_wr_ready),
        .pkt_count    (pkt_count),
        .err_count    (err_count),
        .busy         (busy),
        .csum_err     (csum_err),
        .ch_err       (ch_err),
        .timeout_err  (timeout_err),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       en;
        logic [3:0] ch;
        logic [7:0] val;
        logic       busy;
        logic [3:0] pulses;  // {csum, ch, timeout, drop}
        logic [3:0] pkt;
        logic [3:0] err;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic vld, input logic [7:0] dat, input logic rdy,
                                input logic en, input logic [3:0] ch, input logic [7:0] val,
                                input logic bsy, input logic [3:0] pulses,
                                input logic [3:0] pkt, input logic [3:0] err);
        vec_t v;
        v.vld = vld; v.dat = dat; v.rdy = rdy; v.en = en; v.ch = ch; v.val = val;
        v.busy = bsy; v.pulses = pulses; v.pkt = pkt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] ch, input logic [7:0] duty, input logic [7:0] cs);
        send(8'hA5);
        send(ch);
        send(duty);
        send(cs);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] pulses_now();
        return {csum_err, ch_err, timeout_err, drop_err};
    endfunction

    initial begin
        int k;
        int en_cycles;
        int drops;
        int csums;
        bit got;
        bit stable;
        bit seen_wr;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; duty_wr_ready = 1'b0;
        tick(); tick();
        chk("rst_en",     duty_wr_en,   0);
        chk("rst_busy",   busy,         0);
        chk("rst_pulses", pulses_now(), 0);
        chk("rst_pkt",    pkt_count,    0);
        chk("rst_err",    err_count,    0);
        rst_n = 1'b1;

        //           vld dat    rdy  en ch val    busy pulses   pkt err
        tbl[0]  = mk(1, 8'hA5, 1,   0, 0, 8'h00, 1, 4'b0000, 0, 0);
        tbl[1]  = mk(1, 8'h03, 1,   0, 0, 8'h00, 1, 4'b0000, 0, 0);
        tbl[2]  = mk(1, 8'h80, 1,   0, 0, 8'h00, 1, 4'b0000, 0, 0);
        tbl[3]  = mk(1, 8'h26, 1,   1, 3, 8'h80, 1, 4'b0000, 0, 0);
        tbl[4]  = mk(0, 8'h00, 1,   0, 0, 8'h00, 0, 4'b0000, 1, 0);
        tbl[5]  = mk(1, 8'hA5, 1,   0, 0, 8'h00, 1, 4'b0000, 1, 0);
        tbl[6]  = mk(1, 8'h03, 1,   0, 0, 8'h00, 1, 4'b0000, 1, 0);
        tbl[7]  = mk(1, 8'h80, 1,   0, 0, 8'h00, 1, 4'b0000, 1, 0);
        tbl[8]  = mk(1, 8'h27, 1,   0, 0, 8'h00, 0, 4'b1000, 1, 1);
        tbl[9]  = mk(0, 8'h00, 1,   0, 0, 8'h00, 0, 4'b0000, 1, 1);
        tbl[10] = mk(1, 8'hA5, 1,   0, 0, 8'h00, 1, 4'b0000, 1, 1);
        tbl[11] = mk(1, 8'h09, 1,   0, 0, 8'h00, 1, 4'b0000, 1, 1);
        tbl[12] = mk(1, 8'h10, 1,   0, 0, 8'h00, 1, 4'b0000, 1, 1);
        tbl[13] = mk(1, 8'hBC, 1,   0, 0, 8'h00, 0, 4'b0100, 1, 2);
        tbl[14] = mk(1, 8'h00, 1,   0, 0, 8'h00, 0, 4'b0000, 1, 2);
        tbl[15] = mk(1, 8'hFF, 1,   0, 0, 8'h00, 0, 4'b0000, 1, 2);
        tbl[16] = mk(1, 8'hA5, 0,   0, 0, 8'h00, 1, 4'b0000, 1, 2);
        tbl[17] = mk(1, 8'h01, 0,   0, 0, 8'h00, 1, 4'b0000, 1, 2);
        tbl[18] = mk(1, 8'h40, 0,   0, 0, 8'h00, 1, 4'b0000, 1, 2);
        tbl[19] = mk(1, 8'hE4, 0,   1, 1, 8'h40, 1, 4'b0000, 1, 2);
        tbl[20] = mk(0, 8'h00, 0,   1, 1, 8'h40, 1, 4'b0000, 1, 2);
        tbl[21] = mk(1, 8'h55, 1,   0, 0, 8'h00, 0, 4'b0001, 2, 3);
        tbl[22] = mk(0, 8'h00, 1,   0, 0, 8'h00, 0, 4'b0000, 2, 3);

        for (int i = 0; i < NV; i++) begin
            rx_valid      = tbl[i].vld;
            rx_data       = tbl[i].dat;
            duty_wr_ready = tbl[i].rdy;
            tick();
            chk($sformatf("v%0d_en", i), duty_wr_en, tbl[i].en);
            if (tbl[i].en) begin
                chk($sformatf("v%0d_ch", i),  duty_wr_ch,  tbl[i].ch);
                chk($sformatf("v%0d_val", i), duty_wr_val, tbl[i].val);
            end
            chk($sformatf("v%0d_busy", i),   busy,         tbl[i].busy);
            chk($sformatf("v%0d_pulses", i), pulses_now(), tbl[i].pulses);
            chk($sformatf("v%0d_pkt", i),    pkt_count,    tbl[i].pkt);
            chk($sformatf("v%0d_err", i),    err_count,    tbl[i].err);
        end
        rx_valid = 1'b0;

        // Backpressure: ready low for 10 cycles of WRITE, a stray byte mid-stall.
        do_reset();
        duty_wr_ready = 1'b0;
        send_pkt(8'h03, 8'h80, 8'h26);
        en_cycles = 0; drops = 0; stable = 1'b1;
        if (duty_wr_en) en_cycles++;
        for (int i = 0; i < 10; i++) begin
            rx_valid = (i == 3);
            rx_data  = 8'h55;
            tick();
            if (duty_wr_en) en_cycles++;
            if (drop_err) drops++;
            if (duty_wr_ch !== 4'd3 || duty_wr_val !== 8'h80) stable = 1'b0;
        end
        rx_valid = 1'b0;
        duty_wr_ready = 1'b1;
        tick();
        if (duty_wr_en) en_cycles++;
        if (drop_err) drops++;
        chk("bp_en_cycles", en_cycles, 11);
        chk("bp_stable",    stable,    1);
        chk("bp_drops",     drops,     1);
        chk("bp_pkt",       pkt_count, 1);
        chk("bp_err",       err_count, 1);

        // Timeout after A5 01, then a normal packet.
        do_reset();
        send(8'hA5);
        send(8'h01);
        k = 0; got = 1'b0;
        while (!got && k < TIMEOUT + 8) begin
            tick();
            k++;
            if (timeout_err) got = 1'b1;
        end
        chk("tmo_cycle", k,         TIMEOUT);
        chk("tmo_busy",  busy,      0);
        chk("tmo_err",   err_count, 1);
        send_pkt(8'h01, 8'h40, 8'hE4);
        chk("tmo_wr_en",  duty_wr_en,  1);
        chk("tmo_wr_ch",  duty_wr_ch,  1);
        chk("tmo_wr_val", duty_wr_val, 8'h40);
        tick();
        chk("tmo_pkt", pkt_count, 1);

        // A byte arriving on the expiry cycle beats the timeout.
        do_reset();
        send(8'hA5);
        repeat (TIMEOUT - 1) tick();
        send(8'h02);
        chk("tmo_race_pulse", timeout_err, 0);
        chk("tmo_race_busy",  busy,        1);
        send(8'h11);
        send(8'hA5 ^ 8'h02 ^ 8'h11);
        chk("tmo_race_wr", duty_wr_en, 1);
        chk("tmo_race_err", err_count, 0);

        // Garbage, 17 good packets (pkt_count wraps), then 20 checksum errors.
        do_reset();
        send(8'h00);
        send(8'hFF);
        chk("garbage_busy", busy, 0);
        for (int i = 0; i < 17; i++) begin
            send_pkt(8'(i % NUM_CH), 8'(i * 13), 8'hA5 ^ 8'(i % NUM_CH) ^ 8'(i * 13));
            tick();
        end
        chk("wrap_pkt", pkt_count, 1);
        chk("wrap_err", err_count, 0);
        csums = 0;
        for (int i = 0; i < 20; i++) begin
            send_pkt(8'h02, 8'h10, (8'hA5 ^ 8'h02 ^ 8'h10) ^ 8'h01);
            if (csum_err) csums++;
        end
        chk("sat_pulses", csums,     20);
        chk("sat_err",    err_count, 15);
        chk("sat_pkt",    pkt_count, 1);

        // Reset during a stalled write.
        duty_wr_ready = 1'b0;
        send_pkt(8'h04, 8'h99, 8'hA5 ^ 8'h04 ^ 8'h99);
        chk("rw_pre_en", duty_wr_en, 1);
        rst_n = 1'b0;
        duty_wr_ready = 1'b1;
        tick();
        chk("rw_en",   duty_wr_en, 0);
        chk("rw_busy", busy,       0);
        chk("rw_pkt",  pkt_count,  0);
        chk("rw_err",  err_count,  0);
        rst_n = 1'b1;
        seen_wr = 1'b0;
        repeat (5) begin
            tick();
            if (duty_wr_en) seen_wr = 1'b1;
        end
        chk("rw_no_write", seen_wr,   0);
        chk("rw_pkt_after", pkt_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
